// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies, counter width.
// Decode uses these same encodings to drive the MDU op field.
package mdu_defs;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product or {remainder, quotient}.
// Signed divide works on magnitudes so truncation is toward zero.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] res,
  output logic        div_zero
);

  logic        sgn;
  logic        is_div;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] q;
  logic [31:0] r;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    sgn      = (op == MDU_MULT) || (op == MDU_DIV);
    is_div   = (op == MDU_DIV) || (op == MDU_DIVU);
    div_zero = (B == 32'd0);
    ext_a    = {{32{sgn & A[31]}}, A};
    ext_b    = {{32{sgn & B[31]}}, B};
    prod     = ext_a * ext_b;
    mag_a    = (sgn && A[31]) ? (32'd0 - A) : A;
    mag_b    = (sgn && B[31]) ? (32'd0 - B) : B;
    // divisor forced nonzero; the result is discarded on divide-by-zero
    dvs      = div_zero ? 32'd1 : mag_b;
    q        = mag_a / dvs;
    r        = mag_a % dvs;
    neg_q    = sgn & (A[31] ^ B[31]);
    neg_r    = sgn & A[31];
    res      = prod;
    if (is_div) begin
      res[63:32] = neg_r ? (32'd0 - r) : r;
      res[31:0]  = neg_q ? (32'd0 - q) : q;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Result is computed at the start edge and released after a fixed latency.
module mdu
  import mdu_defs::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             dz;

  logic [63:0]      ar_res;
  logic             ar_dz;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;

  mdu_arith u_arith (
    .op       (op),
    .A        (A),
    .B        (B),
    .res      (ar_res),
    .div_zero (ar_dz)
  );

  // the completing edge may also accept the next op
  assign accept  = start && ((state == S_IDLE) || (cnt == '0));
  assign is_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
  assign is_mthi = (op == MDU_MTHI);
  assign is_mtlo = (op == MDU_MTLO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      dz     <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          if (!dz) begin
            HI <= res_hi;
            LO <= res_lo;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end
      if (accept) begin
        unique case (1'b1)
          is_mul: begin
            res_hi <= ar_res[63:32];
            res_lo <= ar_res[31:0];
            dz     <= 1'b0;
            cnt    <= CNT_W'(MUL_CYCLES - 1);
            state  <= S_MUL;
            busy   <= 1'b1;
          end
          is_div: begin
            res_hi <= ar_res[63:32];
            res_lo <= ar_res[31:0];
            dz     <= ar_dz;
            cnt    <= CNT_W'(DIV_CYCLES - 1);
            state  <= S_DIV;
            busy   <= 1'b1;
          end
          is_mthi: HI <= A;
          is_mtlo: LO <= A;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mdu;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  logic [31:0] vis_hi = '0;
  logic [31:0] vis_lo = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;
  bit          pend_dz = 1'b0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo, output bit dz);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    dz = 1'b0;
    p  = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = ua * ub;
      3'd2: if (b == 0) dz = 1'b1;
            else p = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 0) dz = 1'b1;
            else p = {32'(ua % ub), 32'(ua / ub)};
      default: ;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Drive a start pulse at a negedge; the following posedge samples it.
  task automatic launch(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    model(o, a, b, pend_hi, pend_lo, pend_dz);
  endtask

  // Busy must hold n cycles while HI/LO keep their old values.
  task automatic expect_run(input string tag, input int n, input bit inject);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        A = $urandom;
        B = $urandom;
      end
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".hold_hi"}, HI, vis_hi);
      check({tag, ".hold_lo"}, LO, vis_lo);
      if (inject && i == 1) begin
        start = 1'b1;
        op = 3'd0;
        A = $urandom;
        B = $urandom;
      end
      if (inject && i == 2) start = 1'b0;
    end
  endtask

  task automatic commit();
    if (!pend_dz) begin
      vis_hi = pend_hi;
      vis_lo = pend_lo;
    end
  endtask

  task automatic finish_check(input string tag);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    check({tag, ".hi"}, HI, vis_hi);
    check({tag, ".lo"}, LO, vis_lo);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    if (o == 3'd0 || o == 3'd1) begin
      expect_run(tag, NM, 1'b0);
      commit();
    end else if (o == 3'd2 || o == 3'd3) begin
      expect_run(tag, ND, 1'b0);
      commit();
    end else if (o == 3'd4) begin
      vis_hi = a;
    end else if (o == 3'd5) begin
      vis_lo = a;
    end
    finish_check(tag);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    #12;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.hi", HI, 32'd0);
    check("reset.lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult.hi_lit", HI, 32'hFFFF_FFFF);
    check("mult.lo_lit", LO, 32'hFFFF_FFFA);
    do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    check("multu.hi_lit", HI, 32'h0000_0002);
    check("multu.lo_lit", LO, 32'hFFFF_FFFA);
    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div.hi_lit", HI, 32'hFFFF_FFFF);
    check("div.lo_lit", LO, 32'hFFFF_FFFD);
    do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf.lo_lit", LO, 32'h8000_0000);
    check("divovf.hi_lit", HI, 32'h0000_0000);

    do_op("mthi", 3'd4, 32'h1234, 32'd0);
    do_op("mtlo", 3'd5, 32'h5678, 32'd0);
    do_op("divu0", 3'd3, 32'd7, 32'd0);
    check("divu0.hi_lit", HI, 32'h1234);
    check("divu0.lo_lit", LO, 32'h5678);

    // start during busy must be ignored
    launch(3'd0, 32'd1000, 32'd7);
    expect_run("ign", NM, 1'b1);
    commit();
    finish_check("ign");
    check("ign.lo_lit", LO, 32'd7000);

    // back-to-back: second op sampled on the edge busy would fall
    launch(3'd1, 32'hDEAD_BEEF, 32'h0000_1000);
    expect_run("b2b1", NM, 1'b0);
    commit();
    launch(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_run("b2b2", NM, 1'b0);
    commit();
    finish_check("b2b2");

    for (int k = 0; k < 30; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (k % 7 == 3) rb = 32'd0;
      if (k % 9 == 4) rb = 32'd1 + 32'($urandom_range(0, 9));
      do_op("rand", ro, ra, rb);
    end

    // async reset in the middle of a DIV
    launch(3'd2, 32'd100, 32'd7);
    expect_run("rst", 3, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.hi", HI, 32'd0);
    check("rst.lo", LO, 32'd0);
    vis_hi = '0;
    vis_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < ND + 2; i++) begin
      @(negedge clk);
      check("rst.late_busy", {31'd0, busy}, 32'd0);
      check("rst.late_hi", HI, 32'd0);
      check("rst.late_lo", LO, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage of the five-stage pipelined CPU. Consumes the two register-file read operands forwarded into E and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, holding results in architectural HI/LO registers. Also executes MTHI/MTLO. Exports `busy` so the hazard unit stalls MFHI/MFLO and further MDU instructions until the operation completes.

## Interface
- `MUL_CYCLES`, 5: cycles `busy` stays high for MULT/MULTU.
- `DIV_CYCLES`, 10: cycles `busy` stays high for DIV/DIVU.

- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request; sampled on rising edge; one-cycle pulse per instruction.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `A` input 32: first operand, rs value; source for MTHI/MTLO.
- `B` input 32: second operand, rt value.
- `busy` output 1: operation in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- FSM states: IDLE, MUL, DIV.
- Down-counter: 4 bits, sized for max(`MUL_CYCLES`, `DIV_CYCLES`) ≤ 15.
- Reset:
  - State goes to IDLE, counter to 0.
  - `busy`=0, `HI`=0, `LO`=0.
  - Any pending result is discarded.
- IDLE + `start`, op 0/1:
  - Compute the 64-bit product from A and B at this edge; latch it into internal `res_hi`/`res_lo`.
  - Load counter = `MUL_CYCLES`-1; go to MUL.
  - MULT is a signed×signed product; MULTU is unsigned.
- IDLE + `start`, op 2/3:
  - Latch quotient into `res_lo` and remainder into `res_hi`.
  - Load counter = `DIV_CYCLES`-1; go to DIV.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Divide by zero: still runs the full latency and leaves HI/LO unchanged. This is a fixed rule, not undefined behaviour.
- IDLE + `start`, op 4: `HI` <= A at this edge. `busy` never rises.
- IDLE + `start`, op 5: `LO` <= A at this edge. `busy` never rises.
- MUL/DIV, each edge:
  - If counter ≠ 0, decrement it.
  - If counter = 0, copy `res_hi`/`res_lo` to `HI`/`LO` and return to IDLE.
- `start` while not IDLE: ignored entirely; no state, counter or result change. The hazard unit guarantees this does not occur; the MDU does not rely on it.
- Operands are not re-sampled after the start edge, so A and B may change freely while busy.

## Timing
- `start` is sampled at edge T.
- `busy`=1 for exactly N cycles, from after edge T until edge T+N, where N = `MUL_CYCLES` or `DIV_CYCLES`.
- `HI`/`LO` take the new value at edge T+N; `busy` falls at the same edge.
- MFHI/MFLO issued in the cycle after edge T+N read the new value.
- A new `start` is accepted at edge T+N, so back-to-back operations are possible.
- MTHI/MTLO: zero-latency. The new value is visible in the cycle after the start edge.
- `busy` is a pure register output with no combinational path from `start`. The hazard unit ORs `start` itself when it needs same-cycle stalls.
- `reset` asserted mid-operation: `busy` and HI/LO drop to 0 asynchronously. No update occurs after deassertion.

## Structure
- Shared package `mdu_defs` holds:
  - op encodings `MDU_MULT` … `MDU_MTLO`;
  - default latencies;
  - counter width.
- The decode stage uses the same package to generate `op`.
- One natural sub-module, `mdu_arith`: purely combinational.
  - Inputs: op, A, B.
  - Outputs: 64-bit {hi, lo}, plus a `div_zero` flag.
- FSM, counter and HI/LO registers stay in `mdu`.

## Test plan
- Reset sequence: async `reset` pulse mid-cycle -> `busy`=0, HI=LO=0 immediately, before the next clock edge.
- MULT: A=0xFFFFFFFE (−2), B=3 -> `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV: A=0xFFFFFFF9 (−7), B=2 -> `busy` exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 after MTHI A=0x1234 and MTLO A=0x5678:
  - MTHI/MTLO are visible the next cycle with no `busy`;
  - DIVU holds `busy` for 10 cycles;
  - HI=0x1234 and LO=0x5678 are unchanged afterwards.
- `start` MULT pulsed again during busy with different operands -> ignored; the original result lands on schedule.
- Back-to-back: a new MULT at the edge where `busy` falls is accepted, and `busy` remains high without a gap.
- `reset` at cycle 3 of a DIV -> HI=LO=0; no late update after deassertion.
